// File: rtl/prio_enc_rr_pkg.sv
// -----------------------------------------------------------------------------
// enc_pkg
// Shared constants and helpers for the registered priority encoder family.
//   MODE_FIXED / MODE_RR : selection policy codes for the MODE parameter.
//   popcount()           : number of set bits in a vector of up to 64 bits.
// -----------------------------------------------------------------------------
package enc_pkg;

  localparam int MODE_FIXED = 0;  // highest set index wins
  localparam int MODE_RR    = 1;  // descending search from a rotating pointer

  // Widest supported request vector; callers zero-extend narrower vectors.
  localparam int MAX_N = 64;

  function automatic logic [6:0] popcount(input logic [MAX_N-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < MAX_N; i++) begin
      c = c + 7'(v[i]);
    end
    return c;
  endfunction

endpackage : enc_pkg

// File: rtl/prio_enc_rr_pick.sv
// -----------------------------------------------------------------------------
// prio_pick
// Purely combinational selector used by prio_enc_rr.
//   vec : candidate vector (N bits)
//   ptr : round-robin start position; ignored in fixed-priority mode
//   idx : chosen index (valid only when any = 1)
//   any : at least one bit of vec is set
// Fixed mode returns the highest set index. Round-robin mode searches downward
// from ptr, wrapping from 0 to N-1, and returns the first set bit found.
// -----------------------------------------------------------------------------
module prio_pick
  import enc_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int MODE = MODE_FIXED,
  localparam int W    = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  // Highest set bit of a vector; 0 when the vector is empty.
  function automatic logic [W-1:0] f_highest(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        r = W'(i);
      end
    end
    return r;
  endfunction

  assign any = |vec;

  generate
    if (MODE == MODE_RR) begin : g_rr
      // A descending search from ptr with wrap is the same as: take the
      // highest set bit at or below ptr; if there is none, take the highest
      // set bit overall (which must then lie above ptr).
      logic [N-1:0] w_low_mask;
      logic [N-1:0] w_low_vec;

      for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign w_low_mask[gi] = (W'(gi) <= ptr);
      end

      assign w_low_vec = vec & w_low_mask;
      assign idx       = (|w_low_vec) ? f_highest(w_low_vec) : f_highest(vec);
    end else begin : g_fixed
      logic w_unused_ptr;
      assign w_unused_ptr = ^ptr;
      assign idx          = f_highest(vec);
    end
  endgenerate

endmodule : prio_pick

// File: rtl/prio_enc_rr.sv
// -----------------------------------------------------------------------------
// prio_enc_rr
// Registered priority encoder with a valid/ready output.
// Request pulses are latched into a pending vector; one pending source is
// selected (fixed or round-robin priority) and presented until accepted.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   req      : request pulses/levels, sampled every cycle (N bits)
//   out_idx  : selected source index (W bits)
//   out_vld  : out_idx is valid
//   out_rdy  : consumer accepts out_idx this cycle
//   pend     : registered pending vector (N bits)
//   pend_cnt : registered number of set bits in pend
// -----------------------------------------------------------------------------
module prio_enc_rr
  import enc_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int MODE = MODE_FIXED,
  localparam int W    = $clog2(N),
  localparam int CW   = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [W-1:0]  out_idx,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [N-1:0]  pend,
  output logic [CW-1:0] pend_cnt
);

  logic [N-1:0]  r_pend;
  logic [W-1:0]  r_ptr;
  logic [W-1:0]  r_idx;
  logic          r_vld;
  logic [CW-1:0] r_cnt;

  logic          w_acc;
  logic          w_load;
  logic [N-1:0]  w_clr;
  logic [N-1:0]  w_src;
  logic [N-1:0]  w_pend_next;
  logic [W-1:0]  w_pick_idx;
  logic          w_pick_any;
  logic [W-1:0]  w_ptr_next;

  assign w_acc  = r_vld & out_rdy;
  // A new selection is made whenever the output slot is empty or is being
  // emptied this cycle; otherwise the presented index is frozen.
  assign w_load = ~r_vld | w_acc;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_clr
      assign w_clr[gi] = w_acc & (r_idx == W'(gi));
    end
  endgenerate

  // The index being accepted is excluded from the next selection even if its
  // request re-asserts this cycle; the re-asserted event stays pending and is
  // picked up on a later load.
  assign w_src       = r_pend & ~w_clr;
  assign w_pend_next = w_src | req;

  // Pointer moves to just below the accepted index, wrapping 0 -> N-1.
  assign w_ptr_next  = (r_idx == '0) ? W'(N - 1) : (r_idx - W'(1));

  prio_pick #(
    .N    (N),
    .MODE (MODE)
  ) u_pick (
    .vec (w_src),
    .ptr (r_ptr),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_cnt  <= '0;
      r_vld  <= 1'b0;
      r_idx  <= '0;
      r_ptr  <= W'(N - 1);
    end else begin
      r_pend <= w_pend_next;
      r_cnt  <= CW'(popcount(MAX_N'(w_pend_next)));
      if (w_load) begin
        r_vld <= w_pick_any;
        if (w_pick_any) begin
          r_idx <= w_pick_idx;
        end
      end
      if (w_acc) begin
        r_ptr <= w_ptr_next;
      end
    end
  end

  assign out_idx  = r_idx;
  assign out_vld  = r_vld;
  assign pend     = r_pend;
  assign pend_cnt = r_cnt;

endmodule : prio_enc_rr

// File: tb/tb_prio_enc_rr.sv
// -----------------------------------------------------------------------------
// tb_prio_enc_rr
// Three encoder instances (N=4 fixed, N=4 round-robin, N=8 round-robin) are
// driven with directed vectors. A behavioural model per instance predicts
// every registered output each cycle; directed literal checks pin key points.
// -----------------------------------------------------------------------------
module tb_prio_enc_rr;

  typedef struct packed {
    logic [63:0] pend;
    logic [6:0]  ptr;
    logic        vld;
    logic [6:0]  idx;
  } mstate_t;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_c;
  logic [3:0] req_a, req_b;
  logic [7:0] req_c;
  logic       rdy_a, rdy_b, rdy_c;

  logic [1:0] idx_a, idx_b;
  logic [2:0] idx_c;
  logic       vld_a, vld_b, vld_c;
  logic [3:0] pend_a, pend_b;
  logic [7:0] pend_c;
  logic [2:0] cnt_a, cnt_b;
  logic [3:0] cnt_c;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  mstate_t ma, mb, mc;

  prio_enc_rr #(.N(4), .MODE(0)) u_dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .out_idx(idx_a), .out_vld(vld_a),
    .out_rdy(rdy_a), .pend(pend_a), .pend_cnt(cnt_a)
  );

  prio_enc_rr #(.N(4), .MODE(1)) u_dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .out_idx(idx_b), .out_vld(vld_b),
    .out_rdy(rdy_b), .pend(pend_b), .pend_cnt(cnt_b)
  );

  prio_enc_rr #(.N(8), .MODE(1)) u_dut_c (
    .clk(clk), .rst(rst_c), .req(req_c), .out_idx(idx_c), .out_vld(vld_c),
    .out_rdy(rdy_c), .pend(pend_c), .pend_cnt(cnt_c)
  );

  // Behavioural next-state: clear the accepted bit, OR in new requests, and
  // when the slot is free search the remaining pending bits in priority order.
  function automatic mstate_t model_next(input mstate_t s, input logic [63:0] req,
                                         input logic rdy, input logic rst,
                                         input int n, input int mode);
    mstate_t     t;
    logic [63:0] src;
    bit          found;
    int          j;
    t = s;
    if (rst) begin
      t.pend = '0;
      t.ptr  = 7'(n - 1);
      t.vld  = 1'b0;
      t.idx  = '0;
      return t;
    end
    src = s.pend;
    if (s.vld && rdy) begin
      src[s.idx] = 1'b0;
      t.ptr = (s.idx == 0) ? 7'(n - 1) : (s.idx - 7'd1);
    end
    t.pend = src | req;
    if (!s.vld || rdy) begin
      if (src == 64'd0) begin
        t.vld = 1'b0;
      end else begin
        t.vld = 1'b1;
        found = 1'b0;
        for (int k = 0; k < n; k++) begin
          j = (mode == 0) ? (n - 1 - k) : ((int'(s.ptr) - k + n) % n);
          if (!found && src[j]) begin
            t.idx = 7'(j);
            found = 1'b1;
          end
        end
      end
    end
    return t;
  endfunction

  always @(posedge clk) begin
    ma <= model_next(ma, 64'(req_a), rdy_a, rst_a, 4, 0);
    mb <= model_next(mb, 64'(req_b), rdy_b, rst_b, 4, 1);
    mc <= model_next(mc, 64'(req_c), rdy_c, rst_c, 8, 1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("A.vld",  64'(vld_a),  64'(ma.vld));
      chk("A.idx",  64'(idx_a),  64'(ma.idx));
      chk("A.pend", 64'(pend_a), ma.pend);
      chk("A.cnt",  64'(cnt_a),  64'($countones(ma.pend)));
      chk("B.vld",  64'(vld_b),  64'(mb.vld));
      chk("B.idx",  64'(idx_b),  64'(mb.idx));
      chk("B.pend", 64'(pend_b), mb.pend);
      chk("B.cnt",  64'(cnt_b),  64'($countones(mb.pend)));
      chk("C.vld",  64'(vld_c),  64'(mc.vld));
      chk("C.idx",  64'(idx_c),  64'(mc.idx));
      chk("C.pend", 64'(pend_c), mc.pend);
      chk("C.cnt",  64'(cnt_c),  64'($countones(mc.pend)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int rr_exp [6] = '{3, 2, 1, 0, 3, 2};

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    req_a = 4'hF; req_b = 4'hF; req_c = 8'hFF;
    rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;

    // Reset held three cycles with all requests high: nothing is captured.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_en = 1'b1;
      chk("rst.pend", 64'(pend_a), 64'h0);
      chk("rst.vld",  64'(vld_a),  64'h0);
      chk("rst.idx",  64'(idx_a),  64'h0);
      chk("rst.cnt",  64'(cnt_a),  64'h0);
    end
    chk("model.ptr_b", 64'(mb.ptr), 64'd3);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    req_a = 4'h0; req_b = 4'h0; req_c = 8'h00;
    tick();
    chk("rel.pend", 64'(pend_a), 64'h0);
    chk("rel.vld",  64'(vld_a),  64'h0);
    chk("rel.cnt",  64'(cnt_a),  64'h0);

    // Fixed priority: one pulse of 0101, consumer always ready.
    rdy_a = 1'b1; req_a = 4'b0101;
    tick();
    req_a = 4'b0000;
    $display("fixed: pulse 0101 -> pend=%b cnt=%0d", pend_a, cnt_a);
    chk("fix.pend0", 64'(pend_a), 64'h5);
    chk("fix.cnt0",  64'(cnt_a),  64'd2);
    chk("fix.vld0",  64'(vld_a),  64'd0);
    tick();
    $display("fixed: grant idx=%0d vld=%0d", idx_a, vld_a);
    chk("fix.idx1", 64'(idx_a), 64'd2);
    chk("fix.vld1", 64'(vld_a), 64'd1);
    tick();
    $display("fixed: grant idx=%0d vld=%0d", idx_a, vld_a);
    chk("fix.idx2", 64'(idx_a), 64'd0);
    chk("fix.vld2", 64'(vld_a), 64'd1);
    tick();
    $display("fixed: idle vld=%0d pend=%b", vld_a, pend_a);
    chk("fix.vld3",  64'(vld_a),  64'd0);
    chk("fix.pend3", 64'(pend_a), 64'h0);

    // Fixed priority, frozen selection: higher request arrives while stalled.
    rdy_a = 1'b0; req_a = 4'b0001;
    tick();
    req_a = 4'b1000;
    tick();
    req_a = 4'b0000;
    chk("frz.idx0", 64'(idx_a), 64'd0);
    tick();
    $display("frozen: idx=%0d pend=%b", idx_a, pend_a);
    chk("frz.idx1",  64'(idx_a),  64'd0);
    chk("frz.pend1", 64'(pend_a), 64'h9);
    rdy_a = 1'b1;
    tick();
    $display("frozen: after accept idx=%0d pend=%b", idx_a, pend_a);
    chk("frz.idx2",  64'(idx_a),  64'd3);
    chk("frz.pend2", 64'(pend_a), 64'h8);
    tick();
    chk("frz.vld3", 64'(vld_a), 64'd0);
    rdy_a = 1'b0;

    // Round-robin rotation with every request held high.
    req_b = 4'hF; rdy_b = 1'b1;
    tick();
    chk("rr.cnt0", 64'(cnt_b), 64'd4);
    for (int i = 0; i < 6; i++) begin
      tick();
      $display("rr: grant %0d idx=%0d vld=%0d cnt=%0d", i, idx_b, vld_b, cnt_b);
      chk("rr.idx", 64'(idx_b), 64'(rr_exp[i]));
      chk("rr.vld", 64'(vld_b), 64'd1);
      chk("rr.cnt", 64'(cnt_b), 64'd4);
    end
    req_b = 4'h0; rdy_b = 1'b0;

    // Stall and set-wins on N=8 round-robin.
    rdy_c = 1'b0; req_c = 8'h10;
    tick();
    req_c = 8'h00;
    tick();
    for (int i = 0; i < 5; i++) begin
      $display("stall: cycle %0d idx=%0d vld=%0d pend=%h", i, idx_c, vld_c, pend_c);
      chk("stl.idx",  64'(idx_c),  64'd4);
      chk("stl.vld",  64'(vld_c),  64'd1);
      chk("stl.pend", 64'(pend_c), 64'h10);
      tick();
    end
    rdy_c = 1'b1; req_c = 8'h10;
    tick();
    req_c = 8'h00;
    $display("setwins: pend=%h vld=%0d", pend_c, vld_c);
    chk("sw.pend", 64'(pend_c), 64'h10);
    chk("sw.vld",  64'(vld_c),  64'd0);
    tick();
    chk("sw.idx1", 64'(idx_c), 64'd4);
    chk("sw.vld1", 64'(vld_c), 64'd1);
    tick();
    chk("sw.vld2",  64'(vld_c),  64'd0);
    chk("sw.pend2", 64'(pend_c), 64'h0);

    // Wrap-around: grant 1 so the pointer sits at 0, then 0x82 grants 7 then 1.
    rst_c = 1'b1;
    tick();
    rst_c = 1'b0; req_c = 8'h02;
    tick();
    req_c = 8'h00;
    tick();
    chk("wr.idx0", 64'(idx_c), 64'd1);
    tick();
    chk("wr.vld0", 64'(vld_c), 64'd0);
    req_c = 8'h82;
    tick();
    req_c = 8'h00;
    chk("wr.pend", 64'(pend_c), 64'h82);
    tick();
    $display("wrap: first idx=%0d", idx_c);
    chk("wr.idx1", 64'(idx_c), 64'd7);
    tick();
    $display("wrap: second idx=%0d", idx_c);
    chk("wr.idx2",  64'(idx_c),  64'd1);
    chk("wr.pend2", 64'(pend_c), 64'h02);
    tick();
    chk("wr.vld3", 64'(vld_c), 64'd0);

    // Reset in the middle of an outstanding handshake.
    rdy_c = 1'b0; req_c = 8'h20;
    tick();
    req_c = 8'h80;
    tick();
    req_c = 8'h00;
    tick();
    $display("midrst: before idx=%0d vld=%0d pend=%h", idx_c, vld_c, pend_c);
    chk("mr.idx",  64'(idx_c),  64'd5);
    chk("mr.vld",  64'(vld_c),  64'd1);
    chk("mr.pend", 64'(pend_c), 64'hA0);
    rst_c = 1'b1;
    tick();
    rst_c = 1'b0;
    $display("midrst: after vld=%0d pend=%h", vld_c, pend_c);
    chk("mr.vld1",  64'(vld_c),  64'd0);
    chk("mr.pend1", 64'(pend_c), 64'h0);
    chk("mr.cnt1",  64'(cnt_c),  64'd0);
    rdy_c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr.idle", 64'(vld_c), 64'd0);
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_prio_enc_rr
